// File: rtl/exu_zdet_pkg.sv
// Shared constants and types for the ALU zero-detect consumer block.
// GRP_W must divide 32 so that no reduction group straddles the icc/xcc
// boundary at bit 32.
package exu_zdet_pkg;

  localparam int W32     = 32;
  localparam int W64     = 64;
  localparam int GRP_W   = 16;
  localparam int CNT_W   = 8;
  localparam int TID_W   = 2;
  localparam int NGRP    = W64 / GRP_W;
  localparam int NGRP_LO = W32 / GRP_W;

  // Stage-1 payload: per-group zero flags of predict and sum, plus tag.
  typedef struct packed {
    logic [NGRP-1:0]  zp;
    logic [NGRP-1:0]  zs;
    logic [TID_W-1:0] tid;
  } s1_pay_t;

endpackage

// File: rtl/sparc_exu_aluzdet_grpz.sv
// Per-group zero reducer.
// Ports:
//   data_i  - W-bit slice of a 64-bit vector
//   zero_o  - 1 when the whole slice is zero
module sparc_exu_aluzdet_grpz #(
  parameter int W = 16
) (
  input  logic [W-1:0] data_i,
  output logic         zero_o
);

  assign zero_o = ~|data_i;

endmodule

// File: rtl/sparc_exu_aluzdet.sv
// ALU sum-predict consumer: two-stage valid/ready pipeline producing the
// icc.Z / xcc.Z flags from the predict vector, cross-checked against the
// true adder sum. Disagreements are counted (saturating) and latched in a
// sticky bit for the debug/RAS path.
// Ports:
//   rclk, reset          - clock, synchronous active-high reset
//   in_vld/in_rdy        - input handshake; spr_in, sum_in, in_tid payload
//   out_vld/out_rdy      - output handshake; out_icc_z, out_xcc_z,
//                          out_mis, out_tid payload
//   err_clr              - clears err_cnt and err_sticky
//   err_cnt, err_sticky  - mismatch logging
module sparc_exu_aluzdet
  import exu_zdet_pkg::*;
(
  input  logic             rclk,
  input  logic             reset,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [63:0]      spr_in,
  input  logic [63:0]      sum_in,
  input  logic [TID_W-1:0] in_tid,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             out_icc_z,
  output logic             out_xcc_z,
  output logic             out_mis,
  output logic [TID_W-1:0] out_tid,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky
);

  logic [NGRP-1:0] zp_grp;
  logic [NGRP-1:0] zs_grp;

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    sparc_exu_aluzdet_grpz #(.W(GRP_W)) u_zp (
      .data_i (spr_in[g*GRP_W +: GRP_W]),
      .zero_o (zp_grp[g])
    );
    sparc_exu_aluzdet_grpz #(.W(GRP_W)) u_zs (
      .data_i (sum_in[g*GRP_W +: GRP_W]),
      .zero_o (zs_grp[g])
    );
  end

  s1_pay_t          s1_d, s1_q;
  logic             s1_vld_q;
  logic             s2_vld_q;
  logic             icc_d, xcc_d, mis_d;
  logic             icc_q, xcc_q, mis_q;
  logic [TID_W-1:0] tid2_q;
  logic             s1_adv, s2_adv;
  logic [CNT_W-1:0] err_cnt_d, err_cnt_q;
  logic             err_sticky_d, err_sticky_q;
  logic             mis_take;

  // Flow control: a full pipe stalls only when the output is blocked, so
  // in_rdy depends combinationally on out_rdy and no bubble is introduced.
  assign s2_adv = ~s2_vld_q | out_rdy;
  assign s1_adv = ~s1_vld_q | s2_adv;
  assign in_rdy = s1_adv;

  always_comb begin
    logic icc_s, xcc_s;
    s1_d.zp  = zp_grp;
    s1_d.zs  = zs_grp;
    s1_d.tid = in_tid;
    icc_d    = &s1_q.zp[NGRP_LO-1:0];
    xcc_d    = &s1_q.zp;
    icc_s    = &s1_q.zs[NGRP_LO-1:0];
    xcc_s    = &s1_q.zs;
    mis_d    = (icc_d ^ icc_s) | (xcc_d ^ xcc_s);
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_vld_q <= in_vld;
      if (in_vld) s1_q <= s1_d;
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      s2_vld_q <= 1'b0;
      icc_q    <= 1'b0;
      xcc_q    <= 1'b0;
      mis_q    <= 1'b0;
      tid2_q   <= '0;
    end else if (s2_adv) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        icc_q  <= icc_d;
        xcc_q  <= xcc_d;
        mis_q  <= mis_d;
        tid2_q <= s1_q.tid;
      end
    end
  end

  // Only mismatches that actually leave the block are logged; err_clr wins
  // over a same-cycle mismatch.
  assign mis_take = s2_vld_q & out_rdy & mis_q;

  always_comb begin
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    if (err_clr) begin
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
    end else if (mis_take) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
      err_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign out_vld    = s2_vld_q;
  assign out_icc_z  = icc_q;
  assign out_xcc_z  = xcc_q;
  assign out_mis    = mis_q;
  assign out_tid    = tid2_q;
  assign err_cnt    = err_cnt_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_sparc_exu_aluzdet.sv
// Self-checking bench for sparc_exu_aluzdet: a queue-based reference model
// (ops in flight, each becoming visible one edge after acceptance) plus a
// vector table and directed corner-case sequences.
module tb_sparc_exu_aluzdet;
  import exu_zdet_pkg::*;

  logic             rclk = 1'b0;
  logic             reset, in_vld, in_rdy, out_vld, out_rdy;
  logic             out_icc_z, out_xcc_z, out_mis, err_clr, err_sticky;
  logic [63:0]      spr_in, sum_in;
  logic [TID_W-1:0] in_tid, out_tid;
  logic [CNT_W-1:0] err_cnt;

  always #5 rclk = ~rclk;

  sparc_exu_aluzdet dut (
    .rclk(rclk), .reset(reset), .in_vld(in_vld), .in_rdy(in_rdy),
    .spr_in(spr_in), .sum_in(sum_in), .in_tid(in_tid),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_icc_z(out_icc_z),
    .out_xcc_z(out_xcc_z), .out_mis(out_mis), .out_tid(out_tid),
    .err_clr(err_clr), .err_cnt(err_cnt), .err_sticky(err_sticky)
  );

  typedef struct {
    logic icc, xcc, mis;
    logic [TID_W-1:0] tid;
    int acc;
  } exp_t;

  typedef struct {
    logic [63:0] spr, sum;
    logic [TID_W-1:0] tid;
    logic icc, xcc, mis;
  } vec_t;

  exp_t             mq[$];
  logic [TID_W-1:0] obs[$];
  int               edge_n, m_cnt, n_chk, n_fail;
  logic             m_sticky, last_in_x;
  localparam int    CNT_MAX = (1 << CNT_W) - 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_op(input logic [63:0] p, input logic [63:0] s,
                                  input logic [TID_W-1:0] t, input int a);
    exp_t e;
    logic is, xs;
    e.icc = (p[31:0] == 32'd0);
    e.xcc = (p == 64'd0);
    is    = (s[31:0] == 32'd0);
    xs    = (s == 64'd0);
    e.mis = (e.icc != is) || (e.xcc != xs);
    e.tid = t;
    e.acc = a;
    return e;
  endfunction

  // One clock: check current outputs against the model, take the edge,
  // then advance the model by the transfers that happened on that edge.
  task automatic cycle();
    logic ev, er, in_x, out_x, mis;
    #1;
    ev = (mq.size() > 0) && (edge_n - mq[0].acc >= 1);
    er = (mq.size() < 2) || out_rdy;
    chk("out_vld", 64'(out_vld), 64'(ev));
    chk("in_rdy", 64'(in_rdy), 64'(er));
    chk("err_cnt", 64'(err_cnt), 64'(m_cnt));
    chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
    if (ev) begin
      chk("icc_z", 64'(out_icc_z), 64'(mq[0].icc));
      chk("xcc_z", 64'(out_xcc_z), 64'(mq[0].xcc));
      chk("mis", 64'(out_mis), 64'(mq[0].mis));
      chk("tid", 64'(out_tid), 64'(mq[0].tid));
    end
    in_x  = in_vld & er;
    out_x = ev & out_rdy;
    if (out_x && !reset) obs.push_back(out_tid);
    @(posedge rclk);
    edge_n++;
    last_in_x = in_x & ~reset;
    if (reset) begin
      mq.delete();
      m_cnt    = 0;
      m_sticky = 1'b0;
    end else begin
      mis = 1'b0;
      if (out_x) begin
        mis = mq[0].mis;
        void'(mq.pop_front());
      end
      if (err_clr) begin
        m_cnt    = 0;
        m_sticky = 1'b0;
      end else if (out_x && mis) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        m_sticky = 1'b1;
      end
      if (in_x) mq.push_back(ref_op(spr_in, sum_in, in_tid, edge_n));
    end
    #1;
  endtask

  function automatic logic [63:0] rnd_val();
    logic [31:0] hi, lo;
    hi = ($urandom_range(0, 1) == 0) ? 32'd0 : (32'd1 << $urandom_range(0, 31));
    lo = ($urandom_range(0, 1) == 0) ? 32'd0 : (32'd1 << $urandom_range(0, 31));
    return {hi, lo};
  endfunction

  vec_t tbl[6];
  int   tid_n;

  initial begin
    tbl[0] = '{64'h0, 64'h0, 2'd2, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{64'h0, 64'h1, 2'd3, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{64'h0, 64'h0000_0001_0000_0000, 2'd0, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{64'hFFFF_0000_0000_0000, 64'hFFFF_0000_0000_0000, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{64'h5, 64'h5, 2'd2, 1'b0, 1'b0, 1'b0};

    n_chk = 0; n_fail = 0; edge_n = 0; m_cnt = 0; m_sticky = 1'b0;
    last_in_x = 1'b0;
    reset = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; err_clr = 1'b0;
    spr_in = '0; sum_in = '0; in_tid = '0;
    repeat (2) @(posedge rclk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_icc", 64'(out_icc_z), 64'd0);
    chk("rst_xcc", 64'(out_xcc_z), 64'd0);
    chk("rst_mis", 64'(out_mis), 64'd0);
    chk("rst_tid", 64'(out_tid), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_sticky", 64'(err_sticky), 64'd0);

    // Vector table, one op at a time, latency 2
    out_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_vld = 1'b1; spr_in = tbl[i].spr; sum_in = tbl[i].sum; in_tid = tbl[i].tid;
      cycle();
      in_vld = 1'b0;
      cycle();
      chk("tbl_vld", 64'(out_vld), 64'd1);
      chk("tbl_icc", 64'(out_icc_z), 64'(tbl[i].icc));
      chk("tbl_xcc", 64'(out_xcc_z), 64'(tbl[i].xcc));
      chk("tbl_mis", 64'(out_mis), 64'(tbl[i].mis));
      chk("tbl_tid", 64'(out_tid), 64'(tbl[i].tid));
      cycle();
    end
    chk("tbl_err_cnt", 64'(err_cnt), 64'd2);
    chk("tbl_sticky", 64'(err_sticky), 64'd1);

    // Saturation
    in_vld = 1'b1; spr_in = 64'h0; sum_in = 64'h1; in_tid = 2'd0;
    repeat (300) cycle();
    in_vld = 1'b0;
    repeat (3) cycle();
    chk("sat_cnt", 64'(err_cnt), 64'd255);
    in_vld = 1'b1;
    repeat (5) cycle();
    in_vld = 1'b0;
    repeat (3) cycle();
    chk("sat_hold", 64'(err_cnt), 64'd255);

    // err_clr colliding with a counted mismatch
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    chk("clr_cnt", 64'(err_cnt), 64'd0);
    in_vld = 1'b1;
    repeat (5) cycle();
    in_vld = 1'b0;
    repeat (3) cycle();
    chk("pre_coll_cnt", 64'(err_cnt), 64'd5);
    out_rdy = 1'b0; in_vld = 1'b1;
    cycle();
    in_vld = 1'b0;
    cycle();
    chk("coll_vld", 64'(out_vld), 64'd1);
    chk("coll_mis", 64'(out_mis), 64'd1);
    out_rdy = 1'b1; err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    chk("coll_cnt", 64'(err_cnt), 64'd0);
    chk("coll_sticky", 64'(err_sticky), 64'd0);
    cycle();

    // Back-pressure with four tagged ops
    obs.delete();
    out_rdy = 1'b0; spr_in = 64'h0; sum_in = 64'h0;
    tid_n = 0; in_vld = 1'b1; in_tid = '0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (last_in_x) begin tid_n++; in_tid = TID_W'(tid_n); end
    end
    chk("bp_accepted", 64'(tid_n), 64'd2);
    chk("bp_in_rdy", 64'(in_rdy), 64'd0);
    cycle();
    chk("bp_hold_vld", 64'(out_vld), 64'd1);
    chk("bp_hold_tid", 64'(out_tid), 64'd0);
    out_rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (in_vld && last_in_x) begin
        tid_n++;
        if (tid_n == 4) in_vld = 1'b0;
        else in_tid = TID_W'(tid_n);
      end
    end
    chk("bp_count", 64'(obs.size()), 64'd4);
    for (int i = 0; i < 4 && i < obs.size(); i++) chk("bp_order", 64'(obs[i]), 64'(i));

    // Reset with two ops in flight
    out_rdy = 1'b0; in_vld = 1'b1; spr_in = 64'h0; sum_in = 64'h1; in_tid = 2'd1;
    cycle();
    in_tid = 2'd2;
    cycle();
    in_vld = 1'b0;
    cycle();
    chk("pre_rst_vld", 64'(out_vld), 64'd1);
    obs.delete();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("mid_rst_vld", 64'(out_vld), 64'd0);
    chk("mid_rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("mid_rst_cnt", 64'(err_cnt), 64'd0);
    out_rdy = 1'b1;
    repeat (5) cycle();
    chk("mid_rst_ghost", 64'(obs.size()), 64'd0);

    // Randomized traffic
    in_vld = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      out_rdy = ($urandom_range(0, 9) < 7);
      err_clr = ($urandom_range(0, 63) == 0);
      if (!in_vld || last_in_x) begin
        in_vld = ($urandom_range(0, 3) != 0);
        spr_in = rnd_val();
        sum_in = ($urandom_range(0, 3) != 0) ? spr_in : rnd_val();
        in_tid = TID_W'($urandom);
      end
      cycle();
    end
    err_clr = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
    repeat (4) cycle();
    chk("drain_empty", 64'(mq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sparc_exu_aluzdet.md
Name: sparc_exu_aluzdet

Overview:
- Consumer end of the ALU sum-predict path: takes the sum-predict vector and the true adder sum for one ALU op, and produces the icc.Z and xcc.Z condition-code bits.
- Two-stage valid/ready pipeline. Z flags come from the predict vector (fast path), and the block cross-checks them against the true sum.
- Prediction/sum disagreements are flagged per op, counted, and latched in a sticky error bit for the EXU debug/RAS path.

Parameters:
- GRP_W, 16, width of each first-stage zero-reduction group; must divide 32.
- CNT_W, 8, width of the saturating mismatch counter.
- TID_W, 2, thread-id tag width (4 threads).

Ports:
- rclk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- in_vld  input  1  op valid.
- in_rdy  output  1  block can accept an op this cycle.
- spr_in  input  64  sum-predict vector; all-zero iff rs1+rs2+cin == 0.
- sum_in  input  64  true adder sum for the same op.
- in_tid  input  TID_W  thread tag.
- out_vld  output  1  result valid.
- out_rdy  input  1  downstream accepts result.
- out_icc_z  output  1  predicted Z flag, bits 31:0.
- out_xcc_z  output  1  predicted Z flag, bits 63:0.
- out_mis  output  1  prediction disagreed with the true sum for this op.
- out_tid  output  TID_W  tag of the result.
- err_clr  input  1  clear counter and sticky bit.
- err_cnt  output  CNT_W  saturating mismatch count.
- err_sticky  output  1  set on first counted mismatch.

Behaviour:
- Reset: clock and reset are as decided, one clock `rclk` and synchronous active-high `reset`, sampled on the rising edge of `rclk`.
  - Reset clears both stage valids and err_cnt, and sets err_sticky to 0.
  - out_vld=0 the cycle after reset. All other outputs are 0, except in_rdy=1.
  - Reset mid-operation discards in-flight ops without emitting them.
- Transfer rules:
  - An input transfer occurs when in_vld & in_rdy.
  - An output transfer occurs when out_vld & out_rdy.
  - in_vld must hold with stable data until accepted. out_vld holds with stable data until taken.
- Stage 1 (S1), registered:
  - Per GRP_W group g, zp[g] = ~|spr_in[g], and zs[g] = ~|sum_in[g].
  - Register zp, zs, tid and s1_vld.
- Stage 2 (S2), registered, drives the outputs:
  - icc_p = &zp[low 32 bits groups]; xcc_p = &zp[all groups]. Same rule for icc_s and xcc_s from zs.
  - out_icc_z = icc_p; out_xcc_z = xcc_p.
  - out_mis = (icc_p^icc_s) | (xcc_p^xcc_s).
- Flow control:
  - s2_adv = ~s2_vld | out_rdy.
  - s1_adv = ~s1_vld | s2_adv.
  - in_rdy = s1_adv (combinational from out_rdy; no bubble).
  - Each stage loads its valid from the prior stage whenever it advances.
  - Latency: 2 cycles from input transfer to out_vld when unstalled. Throughput is 1 op/cycle.
- Back-pressure with out_rdy=0 and both stages full: in_rdy=0 and all stage contents hold. Ordering is strictly FIFO.
- Error logging (updated on an output transfer with out_mis=1):
  - err_cnt increments, saturating at 2^CNT_W-1 (no wrap).
  - err_sticky is set to 1.
- err_clr:
  - Sets err_cnt to 0 and err_sticky to 0 on the next edge.
  - Takes priority over a simultaneous counted mismatch; that mismatch is lost.
  - Does not affect the pipeline.
- X-safety: stage data registers may load only on an advance with a valid input. Outputs are don't-care when out_vld=0, except err_* and in_rdy.

Decomposition:
- Shared package exu_zdet_pkg holds:
  - constants for 32/64 widths;
  - NGRP = 64/GRP_W and NGRP_LO = 32/GRP_W;
  - a struct for the S1 payload (zp, zs, tid).
- One natural sub-module, sparc_exu_aluzdet_grpz: a parameterised per-group zero reducer, instantiated NGRP×2.
- Flow control and the error logic stay in the top module.

Test Plan:
- Predict/sum agree, zero: spr_in=0, sum_in=0, tid=2, out_rdy=1 -> 2 cycles later out_vld=1, icc_z=1, xcc_z=1, mis=0, tid=2; err_cnt=0.
- Upper-only non-zero: spr_in=sum_in=64'h0000_0001_0000_0000 -> icc_z=1, xcc_z=0, mis=0.
- Mismatch and saturation:
  - spr_in=0, sum_in=64'h1 -> icc_z=1, xcc_z=1, mis=1, err_sticky=1, err_cnt=1.
  - Repeat 300 ops -> err_cnt=255 and stays there.
- Back-pressure: stream 4 ops (tids 0,1,2,3) with out_rdy=0 -> in_rdy=0 after 2 accepted. Then out_rdy=1 -> outputs tid 0,1,2,3 in order, none lost or duplicated.
- err_clr collision: err_cnt=5 and err_clr=1 in the same cycle as a mismatching output transfer -> err_cnt=0 and err_sticky=0 next cycle.
- Reset mid-flight: 2 ops in S1/S2, assert reset one cycle -> out_vld=0, in_rdy=1, err_cnt=0, and the discarded ops never appear.
